// File: rtl/des_block_loader.sv
// Byte-serial loader that assembles eight bytes into a 64-bit block for the DES initial permutation.
// Optional short-block padding (in_last/out_pad) is enabled by defining DES_LOADER_PAD_EN.
module des_block_loader #(
   parameter int DES_BIT_ORDER = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        abort,
   output logic [63:0] out_block,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef DES_LOADER_PAD_EN
   input  logic        in_last,
   output logic [2:0]  out_pad,
`endif
   output logic [3:0]  fill_count
);

   logic [2:0]  cnt;
   logic [63:0] asm_reg;
   logic [63:0] merged;
   logic        is_last;
   logic        accept;
   logic        complete;
   logic        xfer;

`ifdef DES_LOADER_PAD_EN
   assign is_last = in_last;
`else
   assign is_last = 1'b0;
`endif

   // DES numbering puts byte bit 7 at the lowest index of its slot, so the byte is bit-reversed.
   function automatic logic [63:0] place(input logic [7:0] b, input logic [2:0] slot);
      logic [7:0] rev;
      for (int i = 0; i < 8; i++) rev[i] = b[7-i];
      if (DES_BIT_ORDER != 0)
         return {56'd0, rev} << {slot, 3'b000};
      else
         return {56'd0, b} << {~slot, 3'b000};
   endfunction

   assign in_ready   = reset_n && !abort &&
                       (((cnt != 3'd7) && !is_last) || !out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign complete   = accept && ((cnt == 3'd7) || is_last);
   assign xfer       = out_valid && out_ready;
   assign merged     = asm_reg | place(in_byte, cnt);
   assign fill_count = {1'b0, cnt};

   // Completing block goes straight to the output register so the slot counter never reaches 8.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt       <= '0;
         asm_reg   <= '0;
         out_block <= '0;
         out_valid <= 1'b0;
`ifdef DES_LOADER_PAD_EN
         out_pad   <= '0;
`endif
      end else begin
         if (abort || complete) begin
            cnt     <= '0;
            asm_reg <= '0;
         end else if (accept) begin
            cnt     <= cnt + 3'd1;
            asm_reg <= merged;
         end

         if (complete) begin
            out_block <= merged;
            out_valid <= 1'b1;
`ifdef DES_LOADER_PAD_EN
            out_pad   <= ~cnt;
`endif
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_des_block_loader.sv
// Self-checking bench for des_block_loader: both bit orders run side by side against a byte-queue model.
// Padding scenarios are exercised when DES_LOADER_PAD_EN is defined.
module tb_des_block_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        abort;
   logic        out_ready;
   logic        in_ready1, in_ready0;
   logic [63:0] out_block1, out_block0;
   logic        out_valid1, out_valid0;
   logic [3:0]  fill_count1, fill_count0;
`ifdef DES_LOADER_PAD_EN
   logic        in_last;
   logic [2:0]  out_pad1, out_pad0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bytes of the partial block, plus the expected output register.
   logic [7:0]  m_bytes[$];
   bit          m_valid;
   logic [63:0] m_blk1, m_blk0;
   int          m_pad;
   bit          exp_rdy, last_acc;
   logic        obs_rdy1, obs_rdy0;

   always #5 clk = ~clk;

   des_block_loader #(.DES_BIT_ORDER(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready1), .abort(abort), .out_block(out_block1),
      .out_valid(out_valid1), .out_ready(out_ready),
`ifdef DES_LOADER_PAD_EN
      .in_last(in_last), .out_pad(out_pad1),
`endif
      .fill_count(fill_count1));

   des_block_loader #(.DES_BIT_ORDER(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready0), .abort(abort), .out_block(out_block0),
      .out_valid(out_valid0), .out_ready(out_ready),
`ifdef DES_LOADER_PAD_EN
      .in_last(in_last), .out_pad(out_pad0),
`endif
      .fill_count(fill_count0));

   // One clock of stimulus; samples in_ready mid-cycle and advances the model at the edge.
   task automatic drive(input bit v, input logic [7:0] b, input bit ab, input bit rdy,
                        input bit rn, input bit lst);
      bit xfer;
      in_valid  = v;
      in_byte   = b;
      abort     = ab;
      out_ready = rdy;
      reset_n   = rn;
`ifdef DES_LOADER_PAD_EN
      in_last   = lst;
`endif
      exp_rdy = rn && !ab && ((m_bytes.size() < 7 && !lst) || !m_valid || rdy);
      #2;
      obs_rdy1 = in_ready1;
      obs_rdy0 = in_ready0;
      @(posedge clk);
      last_acc = v && exp_rdy;
      if (!rn) begin
         m_bytes.delete();
         m_valid = 0;
         m_blk1  = '0;
         m_blk0  = '0;
         m_pad   = 0;
      end else begin
         xfer = m_valid && rdy;
         if (ab) begin
            m_bytes.delete();
         end else if (last_acc) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 8 || lst) begin
               m_blk1 = '0;
               m_blk0 = '0;
               foreach (m_bytes[k]) begin
                  m_blk0[63-8*k -: 8] = m_bytes[k];
                  for (int i = 0; i < 8; i++) m_blk1[8*k+7-i] = m_bytes[k][i];
               end
               m_pad   = 8 - m_bytes.size();
               m_valid = 1;
               xfer    = 0;
               m_bytes.delete();
            end
         end
         if (xfer) m_valid = 0;
      end
      #1;
   endtask

   task automatic test_reset;
      drive(1, 8'h55, 0, 1, 0, 0);
      drive(1, 8'h55, 0, 1, 0, 0);
      n_checks++;
      if (obs_rdy1 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", obs_rdy1); end
      n_checks++;
      if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", out_valid1, out_valid0);
      end
      n_checks++;
      if (fill_count1 !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_count1); end
      n_checks++;
      if (out_block1 !== 64'd0 || out_block0 !== 64'd0) begin
         n_fail++; $display("FAIL reset_block: got %h/%h expected 0", out_block1, out_block0);
      end
   endtask

   task automatic test_des_order;
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b = (i == 0) ? 8'h80 : 8'h00;
         drive(1, b, 0, 1, 1, 0);
         n_checks++;
         if (fill_count1 !== 4'((i + 1) % 8)) begin
            n_fail++; $display("FAIL des_fill%0d: got %0d expected %0d", i, fill_count1, (i + 1) % 8);
         end
         n_checks++;
         if (out_valid1 !== (i == 7)) begin
            n_fail++; $display("FAIL des_valid%0d: got %b expected %b", i, out_valid1, i == 7);
         end
      end
      n_checks++;
      if (out_block1 !== 64'h0000_0000_0000_0001) begin
         n_fail++; $display("FAIL des_block_80: got %h expected 0000000000000001", out_block1);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
      n_checks++;
      if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL des_valid_one_cycle: got %b expected 0", out_valid1); end
      for (int i = 0; i < 8; i++) drive(1, (i == 7) ? 8'h01 : 8'h00, 0, 1, 1, 0);
      n_checks++;
      if (out_block1 !== 64'h8000_0000_0000_0000 || out_valid1 !== 1'b1) begin
         n_fail++; $display("FAIL des_block_01: got %h v=%b expected 8000000000000000 v=1", out_block1, out_valid1);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
   endtask

   task automatic test_natural;
      logic [7:0] seq [8];
      seq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      for (int i = 0; i < 8; i++) begin
         drive(1, seq[i], 0, 1, 1, 0);
         if (i == 6) begin
            n_checks++;
            if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL nat_early_valid: got %b expected 0", out_valid0); end
         end
      end
      n_checks++;
      if (out_valid0 !== 1'b1 || out_block0 !== 64'h0123_4567_89AB_CDEF) begin
         n_fail++; $display("FAIL nat_block: got %h v=%b expected 0123456789abcdef v=1", out_block0, out_valid0);
      end
      n_checks++;
      if (out_block1 !== m_blk1) begin n_fail++; $display("FAIL nat_des_twin: got %h expected %h", out_block1, m_blk1); end
      drive(0, 8'h00, 0, 1, 1, 0);
   endtask

   task automatic test_backpressure;
      logic [7:0]  b16 [16];
      logic [63:0] held, exp2;
      int          idx = 0;
      bit          seen = 0;
      for (int i = 0; i < 16; i++) b16[i] = 8'($urandom);
      for (int c = 0; c < 16; c++) begin
         drive(1, b16[idx], 0, 0, 1, 0);
         if (last_acc) idx++;
         n_checks++;
         if (obs_rdy1 !== exp_rdy || obs_rdy0 !== exp_rdy) begin
            n_fail++; $display("FAIL bp_in_ready c%0d: got %b/%b expected %b", c, obs_rdy1, obs_rdy0, exp_rdy);
         end
         if (seen) begin
            n_checks++;
            if (out_block0 !== held || out_valid0 !== 1'b1) begin
               n_fail++; $display("FAIL bp_hold c%0d: got %h v=%b expected %h v=1", c, out_block0, out_valid0, held);
            end
         end else if (m_valid) begin
            seen = 1;
            held = {b16[0], b16[1], b16[2], b16[3], b16[4], b16[5], b16[6], b16[7]};
            n_checks++;
            if (out_block0 !== held) begin n_fail++; $display("FAIL bp_first: got %h expected %h", out_block0, held); end
         end
      end
      n_checks++;
      if (fill_count1 !== 4'd7 || obs_rdy1 !== 1'b0) begin
         n_fail++; $display("FAIL bp_stall: got fill=%0d rdy=%b expected fill=7 rdy=0", fill_count1, obs_rdy1);
      end
      drive(1, b16[idx], 0, 1, 1, 0);
      exp2 = {b16[8], b16[9], b16[10], b16[11], b16[12], b16[13], b16[14], b16[15]};
      n_checks++;
      if (out_valid0 !== 1'b1 || out_block0 !== exp2) begin
         n_fail++; $display("FAIL bp_swap: got %h v=%b expected %h v=1", out_block0, out_valid0, exp2);
      end
      n_checks++;
      if (out_block1 !== m_blk1) begin n_fail++; $display("FAIL bp_swap_des: got %h expected %h", out_block1, m_blk1); end
      drive(0, 8'h00, 0, 1, 1, 0);
      n_checks++;
      if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid1); end
   endtask

   task automatic test_abort;
      int idx = 0;
      int cyc = 0;
      for (int i = 0; i < 3; i++) drive(1, 8'($urandom), 0, 1, 1, 0);
      n_checks++;
      if (fill_count1 !== 4'd3) begin n_fail++; $display("FAIL abort_pre_fill: got %0d expected 3", fill_count1); end
      drive(1, 8'hFF, 1, 1, 1, 0);
      n_checks++;
      if (obs_rdy1 !== 1'b0 || fill_count1 !== 4'd0) begin
         n_fail++; $display("FAIL abort_cycle: got rdy=%b fill=%0d expected rdy=0 fill=0", obs_rdy1, fill_count1);
      end
      while (!m_valid && cyc < 20) begin
         drive(1, 8'(8'h11 + idx), 0, 1, 1, 0);
         if (last_acc) idx++;
         cyc++;
      end
      n_checks++;
      if (out_valid0 !== 1'b1 || out_block0 !== 64'h1112_1314_1516_1718) begin
         n_fail++; $display("FAIL abort_block: got %h v=%b expected 1112131415161718 v=1", out_block0, out_valid0);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 13; i++) drive(1, 8'($urandom), 0, 0, 1, 0);
      n_checks++;
      if (out_valid1 !== 1'b1 || fill_count1 !== 4'd5) begin
         n_fail++; $display("FAIL rmid_pre: got v=%b fill=%0d expected v=1 fill=5", out_valid1, fill_count1);
      end
      drive(1, 8'h42, 0, 0, 0, 0);
      n_checks++;
      if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0 || fill_count1 !== 4'd0 ||
          out_block1 !== 64'd0 || out_block0 !== 64'd0) begin
         n_fail++; $display("FAIL rmid_clear: got v=%b/%b fill=%0d blk=%h/%h expected all 0",
                            out_valid1, out_valid0, fill_count1, out_block1, out_block0);
      end
      for (int i = 0; i < 7; i++) begin
         drive(1, 8'($urandom), 0, 1, 1, 0);
         n_checks++;
         if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rmid_no_block%0d: got %b expected 0", i, out_valid1); end
      end
      drive(1, 8'($urandom), 0, 1, 1, 0);
      n_checks++;
      if (out_valid1 !== 1'b1 || out_block1 !== m_blk1) begin
         n_fail++; $display("FAIL rmid_new: got %h v=%b expected %h v=1", out_block1, out_valid1, m_blk1);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
   endtask

`ifdef DES_LOADER_PAD_EN
   task automatic test_pad;
      drive(1, 8'hAA, 0, 1, 1, 0);
      drive(1, 8'hBB, 0, 1, 1, 0);
      drive(1, 8'hCC, 0, 1, 1, 1);
      n_checks++;
      if (out_block0 !== 64'hAABB_CC00_0000_0000 || out_pad0 !== 3'd5 || fill_count0 !== 4'd0) begin
         n_fail++; $display("FAIL pad_short: got %h pad=%0d fill=%0d expected aabbcc0000000000 pad=5 fill=0",
                            out_block0, out_pad0, fill_count0);
      end
      for (int i = 0; i < 8; i++) drive(1, 8'(i + 1), 0, 1, 1, i == 7);
      n_checks++;
      if (out_pad1 !== 3'd0 || out_block0 !== 64'h0102_0304_0506_0708) begin
         n_fail++; $display("FAIL pad_full_last: got %h pad=%0d expected 0102030405060708 pad=0", out_block0, out_pad1);
      end
      drive(0, 8'h00, 0, 1, 1, 0);
   endtask
`endif

   task automatic test_random;
      bit v, ab, rdy, rn, lst;
      for (int c = 0; c < 400; c++) begin
         v   = ($urandom % 4) != 0;
         ab  = ($urandom % 16) == 0;
         rdy = ($urandom % 3) != 0;
         rn  = ($urandom % 64) != 0;
         lst = 0;
`ifdef DES_LOADER_PAD_EN
         lst = ($urandom % 6) == 0;
`endif
         drive(v, 8'($urandom), ab, rdy, rn, lst);
         n_checks++;
         if (obs_rdy1 !== exp_rdy || obs_rdy0 !== exp_rdy) begin
            n_fail++; $display("FAIL rnd_in_ready c%0d: got %b/%b expected %b", c, obs_rdy1, obs_rdy0, exp_rdy);
         end
         n_checks++;
         if (out_valid1 !== m_valid || out_valid0 !== m_valid) begin
            n_fail++; $display("FAIL rnd_out_valid c%0d: got %b/%b expected %b", c, out_valid1, out_valid0, m_valid);
         end
         n_checks++;
         if (fill_count1 !== 4'(m_bytes.size()) || fill_count0 !== 4'(m_bytes.size())) begin
            n_fail++; $display("FAIL rnd_fill c%0d: got %0d/%0d expected %0d", c, fill_count1, fill_count0, m_bytes.size());
         end
         n_checks++;
         if (out_block1 !== m_blk1 || out_block0 !== m_blk0) begin
            n_fail++; $display("FAIL rnd_block c%0d: got %h/%h expected %h/%h", c, out_block1, out_block0, m_blk1, m_blk0);
         end
`ifdef DES_LOADER_PAD_EN
         n_checks++;
         if (out_pad1 !== 3'(m_pad) || out_pad0 !== 3'(m_pad)) begin
            n_fail++; $display("FAIL rnd_pad c%0d: got %0d/%0d expected %0d", c, out_pad1, out_pad0, m_pad);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_des_order();
      test_natural();
      test_backpressure();
      test_abort();
      test_reset_mid();
`ifdef DES_LOADER_PAD_EN
      test_pad();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
